// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file write side.
package regfile_pkg;

    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // One-hot mask selecting a single register of the scoreboard.
    function automatic logic [REG_COUNT-1:0] reg_mask(input logic [ADDR_W-1:0] addr);
        logic [REG_COUNT-1:0] m;
        m       = {REG_COUNT{1'b0}};
        m[addr] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Writeback, issue and register-file write port bundle of the write controller.
interface regfile_write_ctrl_if;
    import regfile_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              lsu_valid;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              lsu_ready;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  alu_ready, lsu_ready, rs1_busy, rs2_busy, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        output alu_ready, lsu_ready, rs1_busy, rs2_busy, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter: ALU has fixed priority unless the LSU has
// waited STARVE_LIMIT consecutive cycles.
module wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    alu_valid,
    input  wb_req_t alu_req,
    input  logic    lsu_valid,
    input  wb_req_t lsu_req,
    output logic    alu_grant,
    output logic    lsu_grant,
    output logic    sel_valid,
    output wb_req_t sel_req
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       starve_hit_s;

    // Grant decision, request mux and starvation counter next state.
    always_comb begin
        starve_hit_s = (starve_q == LIMIT_C);
        lsu_grant    = lsu_valid && (starve_hit_s || !alu_valid);
        alu_grant    = alu_valid && !lsu_grant;
        sel_valid    = alu_grant || lsu_grant;
        if (lsu_grant) begin
            sel_req = lsu_req;
        end else begin
            sel_req = alu_req;
        end
        if (!lsu_valid || lsu_grant) begin
            starve_d = 4'd0;
        end else if (starve_q != LIMIT_C) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register file write controller: arbitrated registered write port plus
// pending-write scoreboard for read-after-write hazard detection.
module regfile_write_ctrl
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_write_ctrl_if.slave  bus
);

    wb_req_t alu_req_s;
    wb_req_t lsu_req_s;
    wb_req_t sel_req_s;
    logic    alu_grant_s;
    logic    lsu_grant_s;
    logic    sel_valid_s;

    logic                 wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic [REG_COUNT-1:0] pending_q, pending_d;

    assign alu_req_s = {bus.alu_rd, bus.alu_data};
    assign lsu_req_s = {bus.lsu_rd, bus.lsu_data};

    wb_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (bus.alu_valid),
        .alu_req   (alu_req_s),
        .lsu_valid (bus.lsu_valid),
        .lsu_req   (lsu_req_s),
        .alu_grant (alu_grant_s),
        .lsu_grant (lsu_grant_s),
        .sel_valid (sel_valid_s),
        .sel_req   (sel_req_s)
    );

    // Write port and scoreboard next state; an issue set overrides a same-edge clear.
    always_comb begin
        wr_en_d   = sel_valid_s && (sel_req_s.rd != REG_ZERO);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (wr_en_d) begin
            wr_addr_d = sel_req_s.rd;
            wr_data_d = sel_req_s.data;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
        pending_d = pending_q;
        if (wr_en_q) begin
            pending_d = pending_d & ~reg_mask(wr_addr_q);
        end else begin
            pending_d = pending_d;
        end
        if (bus.issue_valid && (bus.issue_rd != REG_ZERO)) begin
            pending_d = pending_d | reg_mask(bus.issue_rd);
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;
    end

    // Output register and scoreboard state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
            pending_q <= {REG_COUNT{1'b0}};
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end

    assign bus.alu_ready = alu_grant_s;
    assign bus.lsu_ready = lsu_grant_s;
    assign bus.rs1_busy  = pending_q[bus.rs1_addr];
    assign bus.rs2_busy  = pending_q[bus.rs2_addr];
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;

endmodule
